// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier controller.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pp_add_row.sv
// One partial-product row: adds the multiplicand, gated by a multiplier bit,
// to the running sum. Output is {carry, sum}. Purely combinational.
module pp_add_row
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_sum,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_row
);

    logic [WIDTH-1:0] w_pp;

    assign w_pp  = i_mcand & {WIDTH{i_bit}};
    assign o_row = {1'b0, i_sum} + {1'b0, w_pp};

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: one shift-add step per RUN cycle, WIDTH steps,
// result held in DONE until the consumer handshakes. abort cancels RUN or DONE.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               abort,
    output logic [2*WIDTH-1:0] product,
    output logic               done_valid,
    input  logic               done_ready,
    output logic               busy
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH:0]       w_row;
    logic                 w_accept;
    logic                 w_step;

    assign w_accept = start_valid && (r_state == IDLE);
    assign w_step   = (r_state == RUN) && !abort;

    pp_add_row #(.WIDTH(WIDTH)) u_row (
        .i_sum   (r_acc[2*WIDTH-1:WIDTH]),
        .i_mcand (r_mcand),
        .i_bit   (r_acc[0]),
        .o_row   (w_row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start_valid)               w_next = RUN;
            RUN:  if (abort)                     w_next = IDLE;
                  else if (r_cnt == LAST)        w_next = DONE;
            DONE: if (abort || done_ready)       w_next = IDLE;
            default:                             w_next = IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b1;
        done_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            DONE:    done_valid = 1'b1;
            default: ;
        endcase
    end

    // The accumulator is {hi, lo}; after each right shift the top bit is always
    // zero, so only 2*WIDTH bits are stored and {carry, sum} lands directly in hi.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
        end else if (w_step) begin
            r_acc   <= {w_row, r_acc[WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign product = r_acc;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: transaction-level model checked every cycle, plus
// directed operations with hand-computed results.
module tb_seq_mult_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_valid = 1'b0;
    logic           abort = 1'b0;
    logic           done_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           start_ready;
    logic           done_valid;
    logic           busy;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .abort       (abort),
        .product     (product),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: an accepted request is busy for W cycles, then presents
    // a*b until handshake or abort.
    int          m_cnt;
    bit          m_done;
    logic [15:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
        end else if (m_done) begin
            if (abort || done_ready) m_done <= 1'b0;
        end else if (m_cnt > 0) begin
            if (abort) m_cnt <= 0;
            else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_done <= 1'b1;
            end
        end else if (start_valid) begin
            m_cnt  <= W;
            m_prod <= 16'(a) * 16'(b);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                chk("m_rst_busy", 32'(busy), 32'd0);
                chk("m_rst_done_valid", 32'(done_valid), 32'd0);
                chk("m_rst_product", 32'(product), 32'd0);
            end else begin
                chk("m_start_ready", 32'(start_ready), 32'(!(m_cnt > 0 || m_done)));
                chk("m_busy", 32'(busy), 32'(m_cnt > 0 || m_done));
                chk("m_done_valid", 32'(done_valid), 32'(m_done));
                if (m_done) chk("m_product", 32'(product), 32'(m_prod));
            end
        end
    end

    task automatic wait_dv(input string name, inout int lat);
        do begin
            @(negedge clk);
            lat++;
        end while (!done_valid && lat < 40);
        chk(name, 32'(done_valid), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int hold,
                          input logic ab_start, output logic [15:0] prod,
                          output int lat, output int busy_n);
        int c;
        @(negedge clk);
        a = ia; b = ib; start_valid = 1'b1; abort = ab_start; done_ready = (hold == 0);
        lat = 0; busy_n = 0;
        do begin
            @(negedge clk);
            start_valid = 1'b0; abort = 1'b0; a = ~ia; b = ~ib;
            lat++;
            if (busy) busy_n++;
        end while (!done_valid && lat < 40);
        chk("op_done_seen", 32'(done_valid), 32'd1);
        prod = product;
        c = 1;
        while (c <= hold) begin
            @(negedge clk);
            c++;
            chk("hold_done_valid", 32'(done_valid), 32'd1);
            chk("hold_product", 32'(product), 32'(prod));
            if (busy) busy_n++;
            done_ready = (c > hold);
        end
        @(negedge clk);
        chk("idle_after_hs_busy", 32'(busy), 32'd0);
        chk("idle_after_hs_ready", 32'(start_ready), 32'd1);
        chk("idle_after_hs_dv", 32'(done_valid), 32'd0);
        done_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p;
        int lat, bn, dv_seen;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(start_ready), 32'd1);

        run_op(8'd13, 8'd11, 0, 1'b0, p, lat, bn);
        chk("p_13x11", 32'(p), 32'h008F);
        chk("lat_13x11", 32'(lat), 32'd9);
        chk("busy_13x11", 32'(bn), 32'd9);

        run_op(8'd255, 8'd255, 0, 1'b0, p, lat, bn);
        chk("p_255x255", 32'(p), 32'hFE01);
        chk("lat_255x255", 32'(lat), 32'd9);
        run_op(8'd0, 8'd200, 0, 1'b0, p, lat, bn);
        chk("p_0x200", 32'(p), 32'h0000);
        run_op(8'd200, 8'd0, 0, 1'b1, p, lat, bn);
        chk("p_200x0_abort_idle", 32'(p), 32'h0000);
        chk("lat_200x0", 32'(lat), 32'd9);

        run_op(8'd7, 8'd9, 5, 1'b0, p, lat, bn);
        chk("p_7x9_hold", 32'(p), 32'h003F);
        chk("busy_7x9_hold", 32'(bn), 32'd14);

        // Second request held high through RUN and DONE of the first.
        @(negedge clk);
        a = 8'd5; b = 8'd6; start_valid = 1'b1; done_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            a = 8'd3; b = 8'd3;
            lat++;
        end while (!done_valid && lat < 40);
        chk("q_done_seen", 32'(done_valid), 32'd1);
        chk("q_p_5x6", 32'(product), 32'h001E);
        chk("q_lat", 32'(lat), 32'd9);
        @(negedge clk);
        chk("q_idle_after_hs", 32'(busy), 32'd0);
        chk("q_ready_after_hs", 32'(start_ready), 32'd1);
        @(negedge clk);
        chk("q_second_accepted", 32'(busy), 32'd1);
        start_valid = 1'b0;
        lat = 1;
        wait_dv("q2_done_seen", lat);
        chk("q2_p_3x3", 32'(product), 32'h0009);
        chk("q2_lat", 32'(lat), 32'd9);
        @(negedge clk);
        done_ready = 1'b0;

        // Abort on RUN cycle 4.
        @(negedge clk);
        a = 8'd100; b = 8'd100; start_valid = 1'b1; done_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_run_busy", 32'(busy), 32'd0);
        chk("abort_run_dv", 32'(done_valid), 32'd0);
        chk("abort_run_ready", 32'(start_ready), 32'd1);
        dv_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_valid) dv_seen++;
        end
        chk("abort_run_no_done", 32'(dv_seen), 32'd0);

        // Abort while waiting in DONE.
        @(negedge clk);
        a = 8'd9; b = 8'd9; start_valid = 1'b1; done_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            start_valid = 1'b0;
            lat++;
        end while (!done_valid && lat < 40);
        chk("abort_done_seen", 32'(done_valid), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done_busy", 32'(busy), 32'd0);
        chk("abort_done_dv", 32'(done_valid), 32'd0);
        chk("abort_done_prod_kept", 32'(product), 32'd81);

        // Reset on RUN cycle 3.
        @(negedge clk);
        a = 8'd50; b = 8'd60; start_valid = 1'b1; done_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_busy", 32'(busy), 32'd0);
        chk("rst_run_dv", 32'(done_valid), 32'd0);
        chk("rst_run_product", 32'(product), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dv_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_valid) dv_seen++;
        end
        chk("rst_run_no_done", 32'(dv_seen), 32'd0);

        run_op(8'd15, 8'd17, 0, 1'b0, p, lat, bn);
        chk("p_15x17_after_rst", 32'(p), 32'h00FF);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_valid, input, 1 bit: operands a/b are valid and a multiply is requested.
REQ-005 The block SHALL have port start_ready, output, 1 bit: the controller can accept a request.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplicand, unsigned.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplier, unsigned.
REQ-008 The block SHALL have port abort, input, 1 bit: synchronous cancel of an operation in flight.
REQ-009 The block SHALL have port product, output, 2*WIDTH bits: unsigned result a*b.
REQ-010 The block SHALL have port done_valid, output, 1 bit: product is valid.
REQ-011 The block SHALL have port done_ready, input, 1 bit: the consumer accepts product.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 start_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle with start_valid && start_ready.
REQ-015 On acceptance: latch a into mcand_q, load the accumulator {hi[WIDTH:0], lo[WIDTH-1:0]} with {0, b}, clear the iteration counter, go to RUN.
REQ-016 Each RUN cycle: {c, s} = hi[WIDTH-1:0] + (lo[0] ? mcand_q : 0) via the pp_add_row instance; accumulator <= {c, s, lo} >> 1; counter increments.
REQ-017 The counter SHALL be $clog2(WIDTH) bits; after the RUN cycle with counter == WIDTH-1, the FSM SHALL go to DONE.
REQ-018 done_valid SHALL rise exactly WIDTH+1 cycles after the accepting edge: WIDTH RUN cycles, then DONE.
REQ-019 In DONE: done_valid = 1 and product = accumulator[2*WIDTH-1:0], held stable until done_ready = 1.
REQ-020 A DONE cycle with done_ready = 1 SHALL return the FSM to IDLE; done_valid SHALL be 0 on the next cycle.
REQ-021 A new request SHALL NOT be accepted in the same cycle as a DONE handshake; acceptance earliest one cycle later.
REQ-022 start_valid asserted during RUN or DONE SHALL be ignored; latched operands SHALL NOT change.
REQ-023 abort = 1 in RUN or DONE SHALL force IDLE on the next edge, with done_valid = 0 and product unchanged (no done_valid pulse); abort in IDLE has no effect.
REQ-024 abort and done_ready both high in DONE SHALL behave as abort; the product is considered discarded.
REQ-025 product SHALL be combinationally derived from the accumulator; it is meaningful only while done_valid = 1.
REQ-026 Arithmetic SHALL be fully unsigned with no truncation: (2^WIDTH-1)^2 SHALL be exact in 2*WIDTH bits.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, accumulator 0, mcand_q 0, counter 0.
REQ-028 During and after reset the outputs SHALL be: start_ready = 1 (once rst_n is high), busy = 0, done_valid = 0, product = 0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL discard the operation; no done_valid SHALL follow.
REQ-030 rst_n SHALL be deasserted synchronously to clk by the integrator; the block adds no synchronizer.

Structure
REQ-031 Package mult_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-032 The single sub-module SHALL be pp_add_row: a WIDTH-bit row adding the gated partial product (a & {WIDTH{b_bit}}) to a running sum, with output {carry, sum}; it is purely combinational.
REQ-033 All registers SHALL be in seq_mult_ctrl; pp_add_row SHALL contain no state.

Verification
REQ-034 WIDTH=8, a=13, b=11, done_ready=1 -> product=0x008F, done_valid exactly 9 cycles after accept, busy high for 9 cycles.
REQ-035 a=255, b=255 -> product=0xFE01; a=0, b=200 -> product=0x0000; a=200, b=0 -> product=0x0000.
REQ-036 a=7, b=9, done_ready held 0 for 5 cycles in DONE -> product=0x003F stable and done_valid=1 throughout, IDLE one cycle after done_ready=1.
REQ-037 start_valid with a=3, b=3 during RUN of a=5, b=6 -> result 0x001E; second request accepted only after return to IDLE.
REQ-038 abort at RUN cycle 4 -> IDLE next cycle, no done_valid; rst_n low at RUN cycle 3 -> immediate IDLE, product=0, done_valid=0.
